// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
// Frame FSM state encoding and frame geometry.
package ps2_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_e;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = FRAME_BITS - 3;

  function automatic logic odd_ok(
    input logic [DATA_BITS-1:0] d,
    input logic                 p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO with registered head/valid.
// Pointers carry a wrap bit so full and empty are distinct.
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [AW:0]      wptr_n;
  logic [AW:0]      rptr_n;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;
  logic [WIDTH-1:0] head_n;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  assign wptr_n = wptr + {{AW{1'b0}}, do_push};
  assign rptr_n = rptr + {{AW{1'b0}}, do_pop};

  // The slot being written is not in mem yet, so bypass it to the head.
  always_comb begin
    head_n = '0;
    if (wptr_n == rptr_n) begin
      head_n = '0;
    end else if (do_push &&
                 wptr[AW-1:0] == rptr_n[AW-1:0]) begin
      head_n = wdata;
    end else begin
      head_n = mem[rptr_n[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      valid <= 1'b0;
      rdata <= '0;
    end else begin
      wptr  <= wptr_n;
      rptr  <= rptr_n;
      valid <= (wptr_n != rptr_n);
      rdata <= head_n;
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin conditioning, frame FSM,
// error strobes and a FWFT byte queue for the scan-code consumer.
import ps2_pkg::*;

module ps2_rx_fifo #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow,
  input  logic       err_clr
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic [FW-1:0] flt_cnt;
  logic          flt_clk;
  logic          flt_clk_q;
  logic          fall;
  logic          din;

  rx_state_e     state;
  rx_state_e     state_n;
  logic [2:0]    bitcnt;
  logic [2:0]    bitcnt_n;
  logic [7:0]    shreg;
  logic [7:0]    shreg_n;
  logic          par;
  logic          par_n;
  logic [TW-1:0] tcnt;
  logic [TW-1:0] tcnt_n;
  logic          timeout;
  logic          push_n;
  logic          perr_n;
  logic          ferr_n;

  logic          push_q;
  logic [7:0]    byte_q;
  logic          drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  // Filtered clock flips only after FILTER_LEN opposite samples in a row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flt_cnt   <= '0;
      flt_clk   <= 1'b1;
      flt_clk_q <= 1'b1;
    end else begin
      flt_clk_q <= flt_clk;
      if (clk_sync[1] == flt_clk) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        flt_cnt <= '0;
        flt_clk <= clk_sync[1];
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  assign fall = flt_clk_q & ~flt_clk;
  assign din  = dat_sync[1];

  assign timeout = (state != S_IDLE) && !fall &&
                   (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    par_n    = par;
    push_n   = 1'b0;
    perr_n   = 1'b0;
    ferr_n   = 1'b0;
    tcnt_n   = (fall || state == S_IDLE) ? '0 : tcnt + TW'(1);
    if (timeout) begin
      state_n  = S_IDLE;
      bitcnt_n = '0;
      shreg_n  = '0;
      ferr_n   = 1'b1;
    end else if (fall) begin
      unique case (state)
        S_IDLE: begin
          if (!din) begin
            state_n  = S_DATA;
            bitcnt_n = '0;
          end
        end
        S_DATA: begin
          shreg_n = {din, shreg[7:1]};
          if (bitcnt == 3'(DATA_BITS - 1)) begin
            state_n = S_PARITY;
          end else begin
            bitcnt_n = bitcnt + 3'd1;
          end
        end
        S_PARITY: begin
          par_n   = din;
          state_n = S_STOP;
        end
        S_STOP: begin
          state_n = S_IDLE;
          if (!din) begin
            ferr_n = 1'b1;
          end else if (!odd_ok(shreg, par)) begin
            perr_n = 1'b1;
          end else begin
            push_n = 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      bitcnt     <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      tcnt       <= '0;
      push_q     <= 1'b0;
      byte_q     <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      bitcnt     <= bitcnt_n;
      shreg      <= shreg_n;
      par        <= par_n;
      tcnt       <= tcnt_n;
      push_q     <= push_n;
      parity_err <= perr_n;
      frame_err  <= ferr_n;
      if (push_n) begin
        byte_q <= shreg;
      end
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_q),
    .wdata   (byte_q),
    .pop     (rx_ack),
    .rdata   (rx_data),
    .valid   (rx_valid),
    .drop    (drop)
  );

  // A drop in the same cycle as a clear still leaves the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (err_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: frames queue expected bytes,
// a negedge monitor checks every popped byte and error strobe.
module tb_ps2_rx_fifo;

  localparam int T_OUT = 400;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rx_ack = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  ps2_rx_fifo #(
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (T_OUT),
    .FIFO_DEPTH     (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ack     (rx_ack),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q [$];
  int perr_cnt = 0;
  int ferr_cnt = 0;
  int width_bad = 0;
  int rise_cyc = 0;
  int ferr_cyc = 0;
  int last_fall = 0;
  logic pv = 1'b0;
  logic pf = 1'b0;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    logic [7:0] e;
    if (reset_n) begin
      if (rx_valid && rx_ack) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pop_unexpected actual=%02h required=none",
                   rx_data);
        end else begin
          e = exp_q.pop_front();
          if (rx_data !== e) begin
            failures++;
            $display("FAIL pop_data actual=%02h required=%02h",
                     rx_data, e);
          end
        end
      end
      if (parity_err) perr_cnt++;
      if (frame_err) begin
        ferr_cnt++;
        ferr_cyc = cyc;
      end
      if ((parity_err && pv) || (frame_err && pf)) width_bad++;
      if (rx_valid && !prev_valid) rise_cyc = cyc;
    end
    pv = parity_err;
    pf = frame_err;
    prev_valid = rx_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act,
                       input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d,
                                        input logic p,
                                        input logic stop);
    return {stop, p, d, 1'b0};
  endfunction

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  task automatic send_bits(input logic [10:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = b[i];
      repeat (15) tick();
      ps2_clk = 1'b0;
      last_fall = cyc;
      repeat (30) tick();
      ps2_clk = 1'b1;
      repeat (15) tick();
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit accept);
    if (accept) exp_q.push_back(d);
    send_bits(frame(d, odd_par(d), 1'b1), 11);
    repeat (10) tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && rx_valid; i++) begin
      rx_ack = 1'b1;
      tick();
    end
    rx_ack = 1'b0;
    tick();
  endtask

  int p0;
  int f0;
  int d;

  // PS/2 clock scaled to 60 sysclk cycles so the run stays short.
  initial begin
    repeat (3) tick();
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_perr", parity_err, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovf", overflow, 0);
    reset_n = 1'b1;
    repeat (5) tick();

    p0 = perr_cnt; f0 = ferr_cnt;
    send_byte(8'h1C, 1);
    check("good_latency", rise_cyc - last_fall, 12);
    check("good_valid", rx_valid, 1);
    check("good_data", rx_data, 8'h1C);
    check("good_noerr", (perr_cnt - p0) + (ferr_cnt - f0), 0);
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
    check("ack_valid_low", rx_valid, 0);

    p0 = perr_cnt; f0 = ferr_cnt;
    send_bits(frame(8'h1C, 1'b1, 1'b1), 11);
    repeat (10) tick();
    check("par_pulse", perr_cnt - p0, 1);
    check("par_nofe", ferr_cnt - f0, 0);
    check("par_nopush", rx_valid, 0);
    send_byte(8'hF0, 1);
    check("f0_valid", rx_valid, 1);
    drain();

    f0 = ferr_cnt;
    send_bits(frame(8'h1C, 1'b0, 1'b1), 5);
    repeat (T_OUT + 40) tick();
    check("to_pulse", ferr_cnt - f0, 1);
    d = ferr_cyc - last_fall;
    check("to_latency", int'(d >= T_OUT && d <= T_OUT + 20), 1);
    check("to_nopush", rx_valid, 0);
    send_byte(8'h1C, 1);
    drain();

    p0 = perr_cnt; f0 = ferr_cnt;
    send_bits(frame(8'h1C, 1'b0, 1'b0), 11);
    repeat (10) tick();
    check("stop_pulse", ferr_cnt - f0, 1);
    check("stop_noperr", perr_cnt - p0, 0);
    check("stop_nopush", rx_valid, 0);

    for (int i = 1; i <= 9; i++) send_byte(8'(i), i <= 8);
    check("ovf_set", overflow, 1);
    check("ovf_head", rx_data, 8'h01);
    drain();
    check("ovf_empty", rx_valid, 0);
    check("ovf_still", overflow, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ovf_clr", overflow, 0);

    p0 = perr_cnt; f0 = ferr_cnt;
    ps2_data = 1'b0;
    tick();
    ps2_clk = 1'b0;
    repeat (5) tick();
    ps2_clk = 1'b1;
    repeat (20) tick();
    ps2_data = 1'b1;
    repeat (5) tick();
    send_byte(8'h29, 1);
    drain();
    check("glitch_noerr", (perr_cnt - p0) + (ferr_cnt - f0), 0);

    for (int i = 8'h11; i <= 8'h18; i++) send_byte(8'(i), 1);
    check("full_noovf", overflow, 0);
    exp_q.push_back(8'h19);
    send_bits(frame(8'h19, odd_par(8'h19), 1'b1), 10);
    repeat (15) tick();
    ps2_clk = 1'b0;
    last_fall = cyc;
    repeat (11) tick();
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
    repeat (19) tick();
    ps2_clk = 1'b1;
    repeat (15) tick();
    check("simul_noovf", overflow, 0);
    drain();
    check("simul_drained", exp_q.size(), 0);

    send_byte(8'h33, 1);
    send_bits(frame(8'h5A, 1'b1, 1'b1), 5);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #2;
    check("mid_valid", rx_valid, 0);
    check("mid_data", rx_data, 0);
    check("mid_ovf", overflow, 0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (5) tick();
    send_byte(8'h5A, 1);
    check("post_valid", rx_valid, 1);
    check("post_data", rx_data, 8'h5A);
    drain();

    check("pulse_width", width_bad, 0);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
